axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares the single AXI read (AR/R) channel between the instruction cache (port 0) and the data cache (port 1).
//  Only one read burst is in flight at a time; the burst runs from AR accept to the R beat carrying rlast.
//  Sits between the two caches and the top-level AXI master interface (AW/W/B are routed elsewhere).
// PARAMETERS
//  ADDR_W  32  address width of araddr on all ports
//  DATA_W  32  width of rdata on all ports
//  ID_W    4   width of arid/rid; IDs pass through unmodified
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  resetn     in   1       asynchronous active-low reset
//  m0_arid    in   ID_W    icache AR id (icache drives 3)
//  m0_araddr  in   ADDR_W  icache AR address
//  m0_arlen   in   8       icache burst length-1
//  m0_arsize  in   3       icache beat size
//  m0_arburst in   2       icache burst type
//  m0_arvalid in   1       icache AR request
//  m0_arready out  1       AR accept to icache
//  m0_rid     out  ID_W    R id to icache
//  m0_rdata   out  DATA_W  R data to icache
//  m0_rresp   out  2       R response to icache
//  m0_rlast   out  1       last beat to icache
//  m0_rvalid  out  1       R beat valid to icache
//  m0_rready  in   1       icache accepts R beat
//  m1_*       same set as m0_*, for the dcache
//  s_arid/araddr/arlen/arsize/arburst  out  as above  AR fields to the AXI master
//  s_arlock   out  2       always 0
//  s_arcache  out  4       always 0
//  s_arprot   out  3       always 0
//  s_arvalid  out  1       AR valid to the AXI master
//  s_arready  in   1       AXI master accepts AR
//  s_rid/rdata/rresp/rlast/rvalid  in  as above  R channel from the AXI master
//  s_rready   out  1       R ready to the AXI master
// BEHAVIOUR
//  - FSM state[1:0]: IDLE=00, ADDR=01, DATA=10. Reset -> IDLE, grant=0, last_grant=0.
//  - Reset values: s_arvalid, s_rready, m*_arready, m*_rvalid and m*_rlast are 0.
//  - s_ar* fields, m*_rid/rdata/rresp are don't-care whenever their valid signal is 0.
//  - IDLE: all handshake outputs are 0. If any m*_arvalid=1, register grant and go to ADDR.
//    Arbitration therefore costs 1 cycle; nothing passes combinationally in IDLE.
//  - ADDR:
//    - s_ar* fields = fields of the granted port; s_arvalid = granted mX_arvalid.
//    - granted mX_arready = s_arready; the other port's arready = 0.
//    - s_arvalid & s_arready -> DATA.
//  - DATA:
//    - s_rready = granted mX_rready.
//    - Granted port gets s_rid/rdata/rresp/rlast/rvalid; the other port's rvalid = 0.
//    - Beat with s_rvalid & s_rready & s_rlast -> IDLE, and last_grant <= grant.
//  - A requester must hold arvalid and its fields stable until arready. No re-arbitration in ADDR/DATA.
//  - A losing requester's arvalid stays pending; it is served in the next IDLE. Beats are never dropped.
//  - Minimum turnaround: rlast beat -> IDLE -> next ADDR, i.e. one dead cycle between bursts.
//  - Simultaneous m0/m1 arvalid in IDLE resolves per CONFIGURATION.
//  - resetn low at any point (including mid-burst): FSM to IDLE at once and all outputs to reset values.
//    The in-flight burst is abandoned; requesters are reset too.
// CONFIGURATION
//  ARB_RR_EN defined:
//    - Round-robin on a tie: grant = ~last_grant.
//    - A port granted last loses the next tie.
//  ARB_RR_EN undefined:
//    - Fixed priority: dcache (m1) wins every tie.
//    - last_grant register is not built.
// TESTING
//  1. Lone icache AR: araddr=0x1FC0_0000, arlen=7, arid=3.
//     -> s_arvalid 1 cycle after request; 8 beats reach m0; m1_rvalid=0 throughout; back to IDLE after rlast.
//  2. m0 and m1 arvalid in the same cycle, ARB_RR_EN undefined.
//     -> m1 burst completes first, then m0; m0_arready=0 until the m1 rlast beat plus 2 cycles.
//  3. Same stimulus with ARB_RR_EN, repeated 4 times.
//     -> grants alternate m1,m0,m1,m0 (last_grant=0 at reset).
//  4. Backpressure: s_arready low 5 cycles, m0_rready toggling every cycle.
//     -> AR fields stable while s_arvalid=1; exactly 8 beats delivered; no beat lost or duplicated.
//  5. resetn asserted during beat 4 of 8.
//     -> outputs 0 in the same cycle; FSM IDLE after release; a new request then completes normally.
//  6. Single-beat dcache read: arlen=0, arid=1.
//     -> rlast on the first beat; IDLE the next cycle; rid=1 delivered to m1.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-port AXI read-channel arbiter: icache (m0) and dcache (m1) share one AR/R path, one burst at a time.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the dcache wins every simultaneous request.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [ID_W-1:0]   m0_rid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [ID_W-1:0]   m1_rid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ID_W-1:0]   s_arid,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    output logic [1:0]        s_arlock,
    output logic [3:0]        s_arcache,
    output logic [2:0]        s_arprot,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [ID_W-1:0]   s_rid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   grant, grant_nxt;
    logic   tie_pick;
    logic   in_addr, in_data;
    logic   ar_vld, r_rdy, burst_done;

    assign in_addr    = (state == ADDR);
    assign in_data    = (state == DATA);
    assign ar_vld     = in_addr && (grant ? m1_arvalid : m0_arvalid);
    assign r_rdy      = in_data && (grant ? m1_rready : m0_rready);
    assign burst_done = in_data && s_rvalid && r_rdy && s_rlast;

`ifdef ARB_RR_EN
    logic last_grant;

    // Remember who owned the finished burst so that port loses the next tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b0;
        end else if (burst_done) begin
            last_grant <= grant;
        end
    end

    assign tie_pick = ~last_grant;
`else
    assign tie_pick = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            grant <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                // Grant is registered here; nothing reaches the master until ADDR.
                if (m0_arvalid || m1_arvalid) begin
                    grant_nxt = (m0_arvalid && m1_arvalid) ? tie_pick : m1_arvalid;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (ar_vld && s_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (burst_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_arid     = grant ? m1_arid    : m0_arid;
    assign s_araddr   = grant ? m1_araddr  : m0_araddr;
    assign s_arlen    = grant ? m1_arlen   : m0_arlen;
    assign s_arsize   = grant ? m1_arsize  : m0_arsize;
    assign s_arburst  = grant ? m1_arburst : m0_arburst;
    assign s_arlock   = 2'b00;
    assign s_arcache  = 4'b0000;
    assign s_arprot   = 3'b000;
    assign s_arvalid  = ar_vld;
    assign s_rready   = r_rdy;

    assign m0_arready = in_addr && !grant && s_arready;
    assign m1_arready = in_addr &&  grant && s_arready;

    assign m0_rid     = s_rid;
    assign m0_rdata   = s_rdata;
    assign m0_rresp   = s_rresp;
    assign m0_rvalid  = in_data && !grant && s_rvalid;
    assign m0_rlast   = in_data && !grant && s_rlast;

    assign m1_rid     = s_rid;
    assign m1_rdata   = s_rdata;
    assign m1_rresp   = s_rresp;
    assign m1_rvalid  = in_data &&  grant && s_rvalid;
    assign m1_rlast   = in_data &&  grant && s_rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: requester/slave models plus per-scenario checking tasks.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic [3:0]  m0_arid = 4'd0, m1_arid = 4'd0;
    logic [31:0] m0_araddr = 32'd0, m1_araddr = 32'd0;
    logic [7:0]  m0_arlen = 8'd0, m1_arlen = 8'd0;
    logic [2:0]  m0_arsize = 3'd2, m1_arsize = 3'd2;
    logic [1:0]  m0_arburst = 2'd1, m1_arburst = 2'd1;
    logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0;
    logic        m0_arready, m1_arready;
    logic [3:0]  m0_rid, m1_rid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
    logic        m0_rready = 1'b1, m1_rready = 1'b1;

    logic [3:0]  s_arid;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_arlock;
    logic [3:0]  s_arcache;
    logic [2:0]  s_arprot;
    logic        s_arvalid;
    logic        s_arready = 1'b1;
    logic [3:0]  s_rid = 4'd0;
    logic [31:0] s_rdata = 32'd0;
    logic [1:0]  s_rresp = 2'd0;
    logic        s_rlast = 1'b0, s_rvalid = 1'b0;
    logic        s_rready;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Requests: the test side bumps reqN, the model side bumps srvN on each accepted AR.
    int cyc = 0, req0 = 0, req1 = 0, srv0 = 0, srv1 = 0, stall_until = -1;
    logic rtog = 1'b0;
    logic m0_ar_hs = 1'b0, m1_ar_hs = 1'b0, s_ar_hs = 1'b0, s_r_hs = 1'b0;
    logic [31:0] lat_addr = 32'd0, prev_addr = 32'd0, b_addr = 32'd0;
    logic [7:0]  lat_len = 8'd0, prev_len = 8'd0;
    logic [3:0]  lat_id = 4'd0, prev_id = 4'd0, b_id = 4'd0;
    logic busy = 1'b0, prev_pend = 1'b0;
    int rem = 0, bidx = 0;
    logic [31:0] d0_q[$], d1_q[$];
    int grant_q[$];
    int last0 = 0, last1 = 0, m0_rv_cnt = 0, m1_rv_cnt = 0, ar_unstable = 0, resp_err = 0;
    logic [3:0] id0_last = 4'd0, id1_last = 4'd0;

    // Requester + AXI slave model: drive at the falling edge, sample handshakes just before the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                busy = 1'b0; rem = 0; bidx = 0;
            end else begin
                if (m0_ar_hs) srv0++;
                if (m1_ar_hs) srv1++;
                if (s_r_hs) begin
                    bidx++; rem--;
                    if (rem == 0) busy = 1'b0;
                end
                if (s_ar_hs) begin
                    busy = 1'b1; rem = int'(lat_len) + 1; bidx = 0; b_addr = lat_addr; b_id = lat_id;
                end
            end
            m0_arvalid = (req0 != srv0);
            m1_arvalid = (req1 != srv1);
            s_arready  = (cyc > stall_until);
            s_rvalid   = busy;
            s_rdata    = b_addr + 32'(bidx * 4);
            s_rid      = b_id;
            s_rlast    = busy && (rem == 1);
            s_rresp    = {1'b0, busy && (rem == 1)};
            m0_rready  = rtog ? ~m0_rready : 1'b1;
            m1_rready  = 1'b1;
            #4;
            m0_ar_hs = m0_arvalid && m0_arready;
            m1_ar_hs = m1_arvalid && m1_arready;
            s_ar_hs  = s_arvalid && s_arready;
            lat_addr = s_araddr; lat_len = s_arlen; lat_id = s_arid;
            if (s_ar_hs) grant_q.push_back(m1_ar_hs ? 1 : (m0_ar_hs ? 0 : 9));
            if (prev_pend && (!s_arvalid || s_araddr != prev_addr || s_arlen != prev_len || s_arid != prev_id))
                ar_unstable++;
            prev_pend = s_arvalid && !s_arready;
            prev_addr = s_araddr; prev_len = s_arlen; prev_id = s_arid;
            s_r_hs = s_rvalid && s_rready;
            if (m0_rvalid && m0_rready) begin
                d0_q.push_back(m0_rdata); id0_last = m0_rid;
                if (m0_rlast) last0++;
                if (m0_rresp !== {1'b0, m0_rlast}) resp_err++;
            end
            if (m1_rvalid && m1_rready) begin
                d1_q.push_back(m1_rdata); id1_last = m1_rid;
                if (m1_rlast) last1++;
                if (m1_rresp !== {1'b0, m1_rlast}) resp_err++;
            end
            if (m0_rvalid) m0_rv_cnt++;
            if (m1_rvalid) m1_rv_cnt++;
        end
    end

    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (req0 == srv0 && req1 == srv1 && !busy && !s_arvalid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [7:0] hs_outs();
        return {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast};
    endfunction

    task automatic test_reset;
        tick(); tick();
        checks++;
        if (hs_outs() !== 8'h00) begin
            errors++; $display("FAIL reset_outputs: got %b required 00000000", hs_outs());
        end
        m0_araddr = 32'h1FC0_0000; m0_arid = 4'd3; req0++;
        tick(); tick();
        checks++;
        if (s_arvalid !== 1'b0 || m0_arready !== 1'b0) begin
            errors++; $display("FAIL reset_hold_req: s_arvalid=%b m0_arready=%b required 0 0", s_arvalid, m0_arready);
        end
        checks++;
        if ({s_arlock, s_arcache, s_arprot} !== 9'd0) begin
            errors++; $display("FAIL ar_constants: got %h required 0", {s_arlock, s_arcache, s_arprot});
        end
        req0 = srv0;
        tick();
        resetn = 1'b1;
        tick();
        checks++;
        if (hs_outs() !== 8'h00) begin
            errors++; $display("FAIL post_reset_idle: got %b required 00000000", hs_outs());
        end
    endtask

    task automatic test_lone_icache;
        int b0, m1c, l0, re;
        bit ok;
        b0 = d0_q.size(); m1c = m1_rv_cnt; l0 = last0; re = resp_err;
        m0_araddr = 32'h1FC0_0000; m0_arlen = 8'd7; m0_arid = 4'd3; m0_arsize = 3'd2; m0_arburst = 2'd1;
        req0++;
        tick();
        checks++;
        if (s_arvalid !== 1'b0) begin
            errors++; $display("FAIL lone_arb_cycle: s_arvalid=%b required 0", s_arvalid);
        end
        tick();
        checks++;
        if ({s_arvalid, m0_arready, m1_arready} !== 3'b110) begin
            errors++; $display("FAIL lone_addr_hs: arvalid/m0rdy/m1rdy=%b required 110", {s_arvalid, m0_arready, m1_arready});
        end
        checks++;
        if (s_araddr !== 32'h1FC0_0000 || s_arlen !== 8'd7 || s_arid !== 4'd3 || s_arsize !== 3'd2 || s_arburst !== 2'd1) begin
            errors++; $display("FAIL lone_ar_fields: addr=%h len=%0d id=%0d size=%0d burst=%0d required 1fc00000 7 3 2 1",
                               s_araddr, s_arlen, s_arid, s_arsize, s_arburst);
        end
        wait_done(40, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL lone_timeout: burst did not finish, got 0 required 1");
        end
        checks++;
        if (d0_q.size() !== b0 + 8) begin
            errors++; $display("FAIL lone_beats: got %0d required 8", d0_q.size() - b0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (d0_q[b0 + i] !== 32'h1FC0_0000 + 32'(i * 4)) begin
                    errors++; $display("FAIL lone_data[%0d]: got %h required %h", i, d0_q[b0 + i], 32'h1FC0_0000 + 32'(i * 4));
                end
            end
        end
        checks++;
        if (last0 !== l0 + 1 || id0_last !== 4'd3 || resp_err !== re) begin
            errors++; $display("FAIL lone_last_id: rlast=%0d rid=%0d resp_err=%0d required 1 3 0", last0 - l0, id0_last, resp_err - re);
        end
        checks++;
        if (m1_rv_cnt !== m1c) begin
            errors++; $display("FAIL lone_m1_quiet: m1_rvalid cycles=%0d required 0", m1_rv_cnt - m1c);
        end
        checks++;
        if (s_rready !== 1'b0 || m0_rvalid !== 1'b0) begin
            errors++; $display("FAIL lone_idle: s_rready=%b m0_rvalid=%b required 0 0", s_rready, m0_rvalid);
        end
    endtask

    task automatic test_tie;
        int g, b0, b1, t_last, t_first;
        bit ok;
        g = grant_q.size(); b0 = d0_q.size(); b1 = d1_q.size();
        m0_araddr = 32'h1FC0_0100; m0_arlen = 8'd3; m0_arid = 4'd3;
        m1_araddr = 32'h8000_0200; m1_arlen = 8'd3; m1_arid = 4'd1;
        req0++; req1++;
        t_last = -1; t_first = -1; ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (m0_arready && t_first < 0) t_first = k;
            if (m1_rvalid && m1_rready && m1_rlast && t_last < 0) t_last = k;
            if (req0 == srv0 && req1 == srv1 && !busy && !s_arvalid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || t_last < 0 || t_first !== t_last + 2) begin
            errors++; $display("FAIL tie_m0_arready: first m0_arready at %0d, m1 rlast at %0d, required rlast+2", t_first, t_last);
        end
        checks++;
        if (grant_q.size() !== g + 2) begin
            errors++; $display("FAIL tie_grants: got %0d grants required 2", grant_q.size() - g);
        end else begin
            checks++;
            if (grant_q[g] !== 1 || grant_q[g + 1] !== 0) begin
                errors++; $display("FAIL tie_order: got m%0d,m%0d required m1,m0", grant_q[g], grant_q[g + 1]);
            end
        end
        checks++;
        if (d0_q.size() !== b0 + 4 || d1_q.size() !== b1 + 4) begin
            errors++; $display("FAIL tie_beats: m0=%0d m1=%0d required 4 4", d0_q.size() - b0, d1_q.size() - b1);
        end else begin
            checks++;
            if (d1_q[b1 + 3] !== 32'h8000_020C || d0_q[b0 + 3] !== 32'h1FC0_010C || id1_last !== 4'd1 || id0_last !== 4'd3) begin
                errors++; $display("FAIL tie_data: m1 last=%h id=%0d m0 last=%h id=%0d required 8000020c 1 1fc0010c 3",
                                   d1_q[b1 + 3], id1_last, d0_q[b0 + 3], id0_last);
            end
        end
    endtask

    task automatic test_repeat_tie;
        int g;
        bit ok;
        g = grant_q.size();
        m0_arlen = 8'd1; m1_arlen = 8'd1;
        for (int r = 0; r < 4; r++) begin
            req0++; req1++;
            wait_done(60, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rep_timeout[%0d]: got 0 required 1", r);
            end
        end
        checks++;
        if (grant_q.size() !== g + 8) begin
            errors++; $display("FAIL rep_grants: got %0d required 8", grant_q.size() - g);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (grant_q[g + i] !== ((i % 2 == 0) ? 1 : 0)) begin
                    errors++; $display("FAIL rep_order[%0d]: got m%0d required m%0d", i, grant_q[g + i], (i % 2 == 0) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_tie_after_m1;
        int g, exp_mid, exp_end;
        bit ok;
`ifdef ARB_RR_EN
        exp_mid = 0; exp_end = 1;
`else
        exp_mid = 1; exp_end = 0;
`endif
        g = grant_q.size();
        m0_arlen = 8'd2; m1_arlen = 8'd2;
        req1++;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (srv1 == req1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL m1_first_accept: got 0 required 1");
        end
        req0++; req1++;
        wait_done(80, ok);
        checks++;
        if (!ok || grant_q.size() !== g + 3) begin
            errors++; $display("FAIL after_m1_grants: done=%0d grants=%0d required 1 3", ok, grant_q.size() - g);
        end else begin
            checks++;
            if (grant_q[g] !== 1 || grant_q[g + 1] !== exp_mid || grant_q[g + 2] !== exp_end) begin
                errors++; $display("FAIL after_m1_order: got m%0d,m%0d,m%0d required m1,m%0d,m%0d",
                                   grant_q[g], grant_q[g + 1], grant_q[g + 2], exp_mid, exp_end);
            end
        end
    endtask

    task automatic test_backpressure;
        int b0, u, stalls;
        bit ok;
        b0 = d0_q.size(); u = ar_unstable; stalls = 0;
        m0_araddr = 32'h1FC0_0800; m0_arlen = 8'd7; m0_arid = 4'd3;
        stall_until = cyc + 5;
        rtog = 1'b1;
        req0++;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (s_arvalid && !s_arready) stalls++;
            if (req0 == srv0 && !busy && !s_arvalid) begin
                ok = 1'b1;
                break;
            end
        end
        rtog = 1'b0;
        checks++;
        if (!ok || stalls !== 4) begin
            errors++; $display("FAIL bp_stall: done=%0d stalled cycles=%0d required 1 4", ok, stalls);
        end
        checks++;
        if (ar_unstable !== u) begin
            errors++; $display("FAIL bp_ar_stable: changes=%0d required 0", ar_unstable - u);
        end
        checks++;
        if (d0_q.size() !== b0 + 8) begin
            errors++; $display("FAIL bp_beats: got %0d required 8", d0_q.size() - b0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (d0_q[b0 + i] !== 32'h1FC0_0800 + 32'(i * 4)) begin
                    errors++; $display("FAIL bp_data[%0d]: got %h required %h", i, d0_q[b0 + i], 32'h1FC0_0800 + 32'(i * 4));
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        int b0, b1;
        bit ok;
        b0 = d0_q.size();
        m0_araddr = 32'h1FC0_0C00; m0_arlen = 8'd7; m0_arid = 4'd3;
        req0++;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (d0_q.size() == b0 + 3 && m0_rvalid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rst_reach_beat4: got 0 required 1");
        end
        resetn = 1'b0;
        req0 = srv0; req1 = srv1;
        #1;
        checks++;
        if (hs_outs() !== 8'h00) begin
            errors++; $display("FAIL rst_mid_outputs: got %b required 00000000", hs_outs());
        end
        tick(); tick();
        resetn = 1'b1;
        tick();
        checks++;
        if (hs_outs() !== 8'h00 || d0_q.size() !== b0 + 3) begin
            errors++; $display("FAIL rst_release: outs=%b beats=%0d required 00000000 3", hs_outs(), d0_q.size() - b0);
        end
        b1 = d1_q.size();
        m1_araddr = 32'h8000_2000; m1_arlen = 8'd1; m1_arid = 4'd1;
        req1++;
        wait_done(40, ok);
        checks++;
        if (!ok || d1_q.size() !== b1 + 2) begin
            errors++; $display("FAIL rst_next_burst: done=%0d beats=%0d required 1 2", ok, d1_q.size() - b1);
        end else begin
            checks++;
            if (d1_q[b1] !== 32'h8000_2000 || d1_q[b1 + 1] !== 32'h8000_2004) begin
                errors++; $display("FAIL rst_next_data: got %h %h required 80002000 80002004", d1_q[b1], d1_q[b1 + 1]);
            end
        end
    endtask

    task automatic test_single_beat;
        int b1, l1, m0c, re;
        bit found;
        b1 = d1_q.size(); l1 = last1; m0c = m0_rv_cnt; re = resp_err;
        m1_araddr = 32'h8000_3000; m1_arlen = 8'd0; m1_arid = 4'd1;
        req1++;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (m1_rvalid) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || d1_q.size() !== b1) begin
            errors++; $display("FAIL single_first_beat: seen=%0d earlier beats=%0d required 1 0", found, d1_q.size() - b1);
        end
        checks++;
        if (m1_rlast !== 1'b1 || m1_rid !== 4'd1 || m1_rdata !== 32'h8000_3000 || m1_rresp !== 2'b01) begin
            errors++; $display("FAIL single_beat: rlast=%b rid=%0d rdata=%h rresp=%b required 1 1 80003000 01",
                               m1_rlast, m1_rid, m1_rdata, m1_rresp);
        end
        tick();
        checks++;
        if (hs_outs() !== 8'h00) begin
            errors++; $display("FAIL single_idle_next: got %b required 00000000", hs_outs());
        end
        checks++;
        if (last1 !== l1 + 1 || id1_last !== 4'd1 || m0_rv_cnt !== m0c || resp_err !== re) begin
            errors++; $display("FAIL single_tally: rlast=%0d rid=%0d m0_rvalid cycles=%0d resp_err=%0d required 1 1 0 0",
                               last1 - l1, id1_last, m0_rv_cnt - m0c, resp_err - re);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lone_icache();
        test_tie();
        test_repeat_tie();
        test_tie_after_m1();
        test_backpressure();
        test_reset_mid_burst();
        test_single_beat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
